// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the pixel-enable logic and the colour generator.
// Carries pix_en in, and h/v counts, syncs, video_on and line/frame strobes out.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          pix_en;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_end;
  logic          frame_end;

  modport master (
    input  pix_en,
    output h_count, v_count,
    output hsync, vsync, video_on,
    output line_end, frame_end
  );

  modport slave (
    output pix_en,
    input  h_count, v_count,
    input  hsync, vsync, video_on,
    input  line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered syncs and video_on.
// Ports: clk, reset (sync, active-high), bus (master: pix_en in, timing out).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic                clk,
  input  logic                reset,
  vga_timing_gen_if.master    bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_q, v_q;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hs_q, vs_q, vid_q;
  logic          h_wrap;

  // >= rather than == so a stray out-of-range count recovers next tick
  assign h_wrap = (h_q >= H_LAST);

  always_comb begin
    h_nxt = h_q;
    v_nxt = v_q;
    if (bus.pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = (v_q >= V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_nxt = h_q + 1'b1;
      end
    end
  end

  // Sync/video regs are decoded from the next counts so they line up
  // with the counter values presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      vid_q <= 1'b1;
    end else begin
      h_q   <= h_nxt;
      v_q   <= v_nxt;
      hs_q  <= (h_nxt >= HS_LO && h_nxt <= HS_HI) ? H_POL : ~H_POL;
      vs_q  <= (v_nxt >= VS_LO && v_nxt <= VS_HI) ? V_POL : ~V_POL;
      vid_q <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

  assign bus.h_count   = h_q;
  assign bus.v_count   = v_q;
  assign bus.hsync     = hs_q;
  assign bus.vsync     = vs_q;
  assign bus.video_on  = vid_q;
  assign bus.line_end  = bus.pix_en & (h_q == H_LAST);
  assign bus.frame_end = bus.line_end & (v_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance and a tiny
// 8x6 instance for full-frame, vsync and frame_end coverage.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   errors = 0;
  int   checks = 0;
  int   pulses;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) b0 ();
  vga_timing_gen_if #(.CW(4))  b1 ();

  vga_timing_gen #(.CW(10)) u0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b0.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .CW(4)
  ) u1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1.master)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.pix_en = 1'b1;
    b1.pix_en = 1'b1;

    // reset with pix_en high
    step(3);
    chk("rst_h", 32'(b0.h_count), 0);
    chk("rst_v", 32'(b0.v_count), 0);
    chk("rst_hs", 32'(b0.hsync), 1);
    chk("rst_vs", 32'(b0.vsync), 1);
    chk("rst_vid", 32'(b0.video_on), 1);
    chk("rst_le", 32'(b0.line_end), 0);
    rst0 = 1'b0;

    // first line
    step(639);
    chk("h639", 32'(b0.h_count), 639);
    chk("vid639", 32'(b0.video_on), 1);
    step(1);
    chk("vid640", 32'(b0.video_on), 0);
    step(15);
    chk("hs655", 32'(b0.hsync), 1);
    step(1);
    chk("h656", 32'(b0.h_count), 656);
    chk("hs656", 32'(b0.hsync), 0);
    step(95);
    chk("hs751", 32'(b0.hsync), 0);
    step(1);
    chk("hs752", 32'(b0.hsync), 1);
    step(47);
    chk("h799", 32'(b0.h_count), 799);
    chk("le799", 32'(b0.line_end), 1);
    chk("fe799", 32'(b0.frame_end), 0);
    chk("v0", 32'(b0.v_count), 0);
    step(1);
    chk("wrap_h", 32'(b0.h_count), 0);
    chk("wrap_v", 32'(b0.v_count), 1);
    chk("wrap_le", 32'(b0.line_end), 0);
    chk("wrap_vid", 32'(b0.video_on), 1);

    // pix_en stall at end of line
    step(799);
    chk("st_h", 32'(b0.h_count), 799);
    b0.pix_en = 1'b0;
    #1;
    chk("st_le0", 32'(b0.line_end), 0);
    step(1);
    chk("st_h1", 32'(b0.h_count), 799);
    chk("st_v1", 32'(b0.v_count), 1);
    chk("st_hs1", 32'(b0.hsync), 1);
    chk("st_vid1", 32'(b0.video_on), 0);
    step(1);
    chk("st_h2", 32'(b0.h_count), 799);
    chk("st_le2", 32'(b0.line_end), 0);
    b0.pix_en = 1'b1;
    #1;
    chk("st_le3", 32'(b0.line_end), 1);
    step(1);
    chk("st_h4", 32'(b0.h_count), 0);
    chk("st_v4", 32'(b0.v_count), 2);

    // reset mid-line
    step(300);
    chk("mr_h", 32'(b0.h_count), 300);
    rst0 = 1'b1;
    #1;
    chk("mr_fe", 32'(b0.frame_end), 0);
    step(1);
    chk("mr_h0", 32'(b0.h_count), 0);
    chk("mr_v0", 32'(b0.v_count), 0);
    chk("mr_hs", 32'(b0.hsync), 1);
    chk("mr_vs", 32'(b0.vsync), 1);
    chk("mr_vid", 32'(b0.video_on), 1);
    rst0 = 1'b0;

    // small instance: reset levels (H_POL=1 -> inactive 0)
    chk("s_rst_h", 32'(b1.h_count), 0);
    chk("s_rst_hs", 32'(b1.hsync), 0);
    chk("s_rst_vs", 32'(b1.vsync), 1);
    rst1 = 1'b0;

    // one full 48-tick frame
    pulses = 0;
    for (int t = 0; t < 48; t++) begin
      int eh, ev;
      eh = t % 8;
      ev = t / 8;
      chk("s_h", 32'(b1.h_count), 32'(eh));
      chk("s_v", 32'(b1.v_count), 32'(ev));
      chk("s_hs", 32'(b1.hsync), 32'(eh == 5 || eh == 6));
      chk("s_vs", 32'(b1.vsync), 32'(ev != 4));
      chk("s_vid", 32'(b1.video_on), 32'(eh < 4 && ev < 3));
      chk("s_le", 32'(b1.line_end), 32'(eh == 7));
      chk("s_fe", 32'(b1.frame_end), 32'(eh == 7 && ev == 5));
      if (b1.frame_end) pulses++;
      step(1);
    end
    chk("s_pulses", 32'(pulses), 1);
    chk("s_end_h", 32'(b1.h_count), 0);
    chk("s_end_v", 32'(b1.v_count), 0);

    // small instance: reset at (3,2)
    step(19);
    chk("s_mr_h", 32'(b1.h_count), 3);
    chk("s_mr_v", 32'(b1.v_count), 2);
    rst1 = 1'b1;
    #1;
    chk("s_mr_fe", 32'(b1.frame_end), 0);
    step(1);
    chk("s_mr_h0", 32'(b1.h_count), 0);
    chk("s_mr_v0", 32'(b1.v_count), 0);
    chk("s_mr_hs", 32'(b1.hsync), 0);
    chk("s_mr_vs", 32'(b1.vsync), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator that replaces the standalone vertical counter.
- Holds a horizontal and a vertical counter, and produces hsync, vsync, a video_on window, line_end and frame_end strobes.
- Sits between the pixel-clock enable logic and the pixel/colour generator.
- Defaults give 640x480 at 60 Hz: 800 clocks per line, 525 lines per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; counters advance only when 1
- h_count  out  CW  current pixel column, 0..H_TOTAL-1
- v_count  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- video_on  out  1  1 when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_end  out  1  one-tick strobe on the last pixel of a line
- frame_end  out  1  one-tick strobe on the last pixel of a frame

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Segment order in both axes: active, front porch, sync, back porch.
- Reset (reset=1 at a clk edge):
  - h_count=0, v_count=0
  - hsync=~H_POL, vsync=~V_POL (inactive levels)
  - video_on=1 (position 0,0 is active)
  - Reset has priority over pix_en.
  - Reset mid-frame returns to (0,0) in one cycle; there is no partial-line completion.
- Counting, on a clk edge with pix_en=1:
  - If h_count==H_TOTAL-1: h_count<=0, and v_count<=(v_count==V_TOTAL-1) ? 0 : v_count+1.
  - Otherwise h_count<=h_count+1 and v_count holds.
  - With pix_en=0, all registers hold.
  - Counters never exceed TOTAL-1. An out-of-range value can only exist after a parameter misuse; if one occurs, wrap to 0 on the next tick.
- hsync, vsync and video_on are registered. They are computed from the next counter values, so they are always aligned with the h_count/v_count presented in the same cycle; there is no pipeline offset.
  - hsync active for H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1 (default 656..751).
  - vsync active for V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1 (default 490..491). vsync is line-based and changes only at h wrap.
- Strobes are combinational from registered state:
  - line_end = pix_en & (h_count==H_TOTAL-1)
  - frame_end = line_end & (v_count==V_TOTAL-1)
  - Each is high for at most one clock per pix_en tick.
- Simultaneous events: h wrap and v wrap happen in the same edge at frame end, with no extra idle tick.

Test Plan:
1. Reset with pix_en=1 for 3 clocks -> h_count=0, v_count=0, hsync=1, vsync=1, video_on=1, line_end=0.
2. Free-run from reset with pix_en=1 -> h_count reaches 799 with line_end=1, then h_count=0 and v_count=1. hsync goes low at h=656 and high at h=752. video_on drops at h=640.
3. Run a full frame -> frame_end pulses exactly once after 420000 ticks, at (799,524); next state is (0,0). vsync is low only for v=490..491. video_on=0 for all v>=480.
4. pix_en toggled 1,0,0,1 -> counters and outputs hold during the 0 cycles; line_end stays 0 while pix_en=0 even at h=799.
5. Assert reset at (300,200) -> next cycle (0,0), sync outputs inactive, no frame_end pulse.
6. Instantiate H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, CW=4 -> line is 8 ticks; hsync=1 only at h=5..6; frame_end every 48 ticks.
